// File: rtl/audio_pkg.sv
// Shared constants, types and helpers for the audio serial transmit path.
package audio_pkg;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    // Width of a level counter that must hold 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty and a level count.
module sync_fifo
    import audio_pkg::*;
#(
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned DEPTH   = 4,
    localparam int unsigned LEVEL_W = level_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data_c,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               full;
    logic               wr_en;
    logic               rd_en;
    logic [LEVEL_W-1:0] level_nxt;

    assign wr_en      = push & ~full;
    assign rd_en      = pop & ~empty;
    assign pop_data_c = mem[rd_ptr];

    // Level after this cycle's accepted push/pop.
    always_comb begin
        level_nxt = level + LEVEL_W'(wr_en) - LEVEL_W'(rd_en);
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, level and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == LEVEL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// Multi-slot I2S / left-justified serial transmitter fed by a frame FIFO.
module i2s_tdm_tx
    import audio_pkg::*;
#(
    parameter  int unsigned SAMPLE_W   = 16,
    parameter  int unsigned SLOT_W     = 16,
    parameter  int unsigned CHANNELS   = 2,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned PRESCALE_W = 8,
    localparam int unsigned LEVEL_W    = level_w(FIFO_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         mode,
    input  logic [PRESCALE_W-1:0]        prescaler,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0] in_data,
    output logic                         sclk,
    output logic                         lrclk,
    output logic                         sdata,
    output logic                         underrun,
    output logic [LEVEL_W-1:0]           fifo_level
);

    localparam int unsigned FRAME_W = CHANNELS * SLOT_W;
    localparam int unsigned DATA_W  = CHANNELS * SAMPLE_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned PAD_W   = SLOT_W - SAMPLE_W;

    tx_state_e            state_q;
    tx_state_e            state_nxt;
    logic                 start_c;
    logic                 run_c;

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] presc_eff_c;
    logic                  mode_q;
    logic [BIT_W-1:0]      bitcnt_q;
    logic [FRAME_W-1:0]    shreg_q;

    logic                  tick_c;
    logic                  fall_c;
    logic                  frame_start_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  fifo_empty;
    logic [DATA_W-1:0]     fifo_data_c;
    logic [DATA_W-1:0]     src_c;
    logic [FRAME_W-1:0]    stream_c;
    logic [BIT_W-1:0]      bit_nxt_c;
    logic [BIT_W-1:0]      lead_c;
    logic [BIT_W-1:0]      lr_idx_c;
    logic                  mode_nxt_c;
    logic                  lr_nxt_c;
    logic [LEVEL_W-1:0]    lvl_nxt_c;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_c),
        .push_data  (in_data),
        .pop        (pop_c),
        .pop_data_c (fifo_data_c),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    // Run/idle state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state follows enable.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (enable)  state_nxt = ST_RUN;
            ST_RUN:  if (!enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes: start on the enable rise, run while enabled afterwards.
    always_comb begin
        start_c = 1'b0;
        run_c   = 1'b0;
        case (state_q)
            ST_IDLE: start_c = enable;
            ST_RUN:  run_c   = enable;
            default: ;
        endcase
    end

    // Bit-clock timing, frame boundaries and FIFO handshake.
    always_comb begin
        presc_eff_c   = (prescaler == '0) ? PRESCALE_W'(1) : prescaler;
        tick_c        = run_c & (pcnt_q == (presc_q - PRESCALE_W'(1)));
        fall_c        = tick_c & sclk;
        frame_start_c = start_c | (fall_c & (bitcnt_q == BIT_W'(FRAME_W - 1)));
        pop_c         = frame_start_c & ~fifo_empty;
        push_c        = in_valid & in_ready;
        lvl_nxt_c     = fifo_level + LEVEL_W'(push_c) - LEVEL_W'(pop_c);
    end

    // Lay the popped frame out as one MSB-first stream, slot 0 first, zero padded.
    always_comb begin
        src_c    = pop_c ? fifo_data_c : '0;
        stream_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            stream_c[FRAME_W-1-c*SLOT_W -: SLOT_W] = SLOT_W'(src_c[c*SAMPLE_W +: SAMPLE_W]) << PAD_W;
        end
    end

    // Word select for the bit about to be driven; I2S looks one bit ahead.
    always_comb begin
        if (frame_start_c) begin
            bit_nxt_c = '0;
        end else if (fall_c) begin
            bit_nxt_c = bitcnt_q + BIT_W'(1);
        end else begin
            bit_nxt_c = bitcnt_q;
        end
        mode_nxt_c = frame_start_c ? mode : mode_q;
        lead_c     = (bit_nxt_c == BIT_W'(FRAME_W - 1)) ? '0 : bit_nxt_c + BIT_W'(1);
        lr_idx_c   = (mode_nxt_c == MODE_LJ) ? bit_nxt_c : lead_c;
        lr_nxt_c   = (lr_idx_c >= BIT_W'(FRAME_W / 2));
    end

    // Serial datapath: prescaler, bit counter, shift register and pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q   <= '0;
            presc_q  <= PRESCALE_W'(1);
            mode_q   <= MODE_I2S;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            sclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else if (start_c | run_c) begin
            underrun <= frame_start_c & fifo_empty;
            if (start_c) begin
                pcnt_q <= '0;
                sclk   <= 1'b0;
            end else if (tick_c) begin
                pcnt_q <= '0;
                sclk   <= ~sclk;
            end else begin
                pcnt_q <= pcnt_q + PRESCALE_W'(1);
            end
            if (frame_start_c) begin
                presc_q <= presc_eff_c;
                mode_q  <= mode;
                sdata   <= stream_c[FRAME_W-1];
                shreg_q <= stream_c << 1;
            end else if (fall_c) begin
                sdata   <= shreg_q[FRAME_W-1];
                shreg_q <= shreg_q << 1;
            end
            if (frame_start_c | fall_c) begin
                bitcnt_q <= bit_nxt_c;
                lrclk    <= lr_nxt_c;
            end
        end else begin
            pcnt_q   <= '0;
            bitcnt_q <= '0;
            sclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end
    end

    // Ready reflects the level after this cycle so a full FIFO is never overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (lvl_nxt_c != LEVEL_W'(FIFO_DEPTH));
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: time-based reference model on the default build plus literal checks.
module tb_i2s_tdm_tx;

    logic        clk = 1'b0;
    logic        rst;

    // Instance A: defaults (2 x 16/16, depth 4)
    logic        enable_a, mode_a, in_valid_a, in_ready_a;
    logic [7:0]  prescaler_a;
    logic [31:0] in_data_a;
    logic        sclk_a, lrclk_a, sdata_a, underrun_a;
    logic [2:0]  fifo_level_a;

    // Instance B: 4 x 12-bit samples in 16-bit slots
    logic        enable_b, mode_b, in_valid_b, in_ready_b;
    logic [7:0]  prescaler_b;
    logic [47:0] in_data_b;
    logic        sclk_b, lrclk_b, sdata_b, underrun_b;
    logic [2:0]  fifo_level_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i2s_tdm_tx u_dut_a (
        .clk(clk), .rst(rst), .enable(enable_a), .mode(mode_a), .prescaler(prescaler_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .sclk(sclk_a), .lrclk(lrclk_a), .sdata(sdata_a), .underrun(underrun_a),
        .fifo_level(fifo_level_a)
    );

    i2s_tdm_tx #(.SAMPLE_W(12), .SLOT_W(16), .CHANNELS(4)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .mode(mode_b), .prescaler(prescaler_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .sclk(sclk_b), .lrclk(lrclk_b), .sdata(sdata_b), .underrun(underrun_b),
        .fifo_level(fifo_level_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    logic [31:0] m_q[$];
    logic [31:0] m_frame;
    bit          m_run, m_mode, m_ready, m_und;
    int unsigned m_d, m_p;
    bit          e_sclk, e_lr, e_sd;

    // New frame: stream is slot 0 MSB first then slot 1; empty FIFO plays silence.
    function automatic void load_frame(input logic [7:0] presc, input logic md);
        logic [31:0] f;
        m_d    = 0;
        m_p    = (presc == 8'd0) ? 1 : int'(presc);
        m_mode = md;
        if (m_q.size() > 0) begin
            f       = m_q.pop_front();
            m_frame = {f[15:0], f[31:16]};
        end else begin
            m_frame = 32'd0;
            m_und   = 1'b1;
        end
    endfunction

    initial begin : ref_model
        logic        s_rst, s_en, s_mode, s_valid;
        logic [7:0]  s_presc;
        logic [31:0] s_data;
        bit          s_push;
        int unsigned half, b;
        m_run = 0; m_ready = 0; m_und = 0; m_d = 0; m_p = 1; m_mode = 0; m_frame = '0;
        forever begin
            @(posedge clk);
            s_rst = rst; s_en = enable_a; s_mode = mode_a; s_valid = in_valid_a;
            s_presc = prescaler_a; s_data = in_data_a;
            m_und = 1'b0;
            if (s_rst) begin
                m_q.delete();
                m_run   = 0;
                m_ready = 0;
            end else begin
                s_push = s_valid && m_ready;
                if (!s_en) begin
                    m_run = 0;
                end else if (!m_run) begin
                    m_run = 1;
                    load_frame(s_presc, s_mode);
                end else begin
                    m_d++;
                    if (m_d == 64 * m_p) load_frame(s_presc, s_mode);
                end
                if (s_push) m_q.push_back(s_data);
                m_ready = (m_q.size() != 4);
            end
            if (m_run) begin
                half   = m_d / m_p;
                b      = half / 2;
                e_sclk = (half % 2) == 1;
                e_sd   = m_frame[31 - b];
                e_lr   = m_mode ? (b >= 16) : (((b + 1) % 32) >= 16);
            end else begin
                e_sclk = 0; e_lr = 0; e_sd = 0;
            end
            #1;
            check("sclk",       64'(sclk_a),       64'(e_sclk));
            check("lrclk",      64'(lrclk_a),      64'(e_lr));
            check("sdata",      64'(sdata_a),      64'(e_sd));
            check("underrun",   64'(underrun_a),   64'(m_und));
            check("in_ready",   64'(in_ready_a),   64'(m_ready));
            check("fifo_level", 64'(fifo_level_a), 64'(m_q.size()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable_a = 1'b0; enable_b = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic push_a(input logic [31:0] d);
        int budget = 2000;
        while (!in_ready_a && budget > 0) begin step(); budget--; end
        if (budget == 0) check("push_a_timeout", 64'd1, 64'd0);
        in_valid_a = 1'b1; in_data_a = d;
        step();
        in_valid_a = 1'b0;
    endtask

    // Capture n bits on sclk rising edges; report cycles of the first two rises and underrun count.
    task automatic grab(input bit sel, input int n, output logic [63:0] bits, output logic [63:0] lr,
                        output int r1, output int r2, output int und);
        int   got = 0;
        int   c = 0;
        logic prev, cur;
        bits = '0; lr = '0; r1 = -1; r2 = -1; und = 0;
        prev = sel ? sclk_b : sclk_a;
        while (got < n && c < 5000) begin
            step();
            c++;
            cur = sel ? sclk_b : sclk_a;
            if (sel ? underrun_b : underrun_a) und++;
            if (cur && !prev) begin
                bits = {bits[62:0], (sel ? sdata_b : sdata_a)};
                lr   = {lr[62:0], (sel ? lrclk_b : lrclk_a)};
                if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
                got++;
            end
            prev = cur;
        end
        if (got < n) check("grab_timeout", 64'(got), 64'(n));
    endtask

    // ---------------- directed tests, then random traffic ----------------
    initial begin : stim
        logic [63:0] bits, lr;
        int          r1, r2, und;
        rst = 1'b1; enable_a = 0; mode_a = 0; prescaler_a = 8'd4; in_valid_a = 0; in_data_a = '0;
        enable_b = 0; mode_b = 1'b1; prescaler_b = 8'd2; in_valid_b = 0; in_data_b = '0;
        step(); step();
        check("rst_in_ready", 64'(in_ready_a), 64'd0);
        check("rst_level",    64'(fifo_level_a), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 64'(in_ready_a), 64'd1);

        // 1: I2S, P=4, L=A5F0 R=0F0F
        push_a(32'h0F0F_A5F0);
        push_a(32'h0F0F_A5F0);
        enable_a = 1'b1;
        grab(1'b0, 32, bits, lr, r1, r2, und);
        check("t1_first_rise", 64'(r1), 64'd5);
        check("t1_period",     64'(r2 - r1), 64'd8);
        check("t1_bits",       bits[31:0] & 64'hFFFF_FFFF, 64'hA5F0_0F0F);
        check("t1_lrclk",      lr & 64'hFFFF_FFFF, 64'h0001_FFFE);
        check("t1_underrun",   64'(und), 64'd0);

        // 2: same frame, left-justified
        enable_a = 1'b0;
        step();
        mode_a = 1'b1;
        push_a(32'h0F0F_A5F0);
        enable_a = 1'b1;
        grab(1'b0, 32, bits, lr, r1, r2, und);
        check("t2_bits",     bits & 64'hFFFF_FFFF, 64'hA5F0_0F0F);
        check("t2_lrclk",    lr & 64'hFFFF_FFFF, 64'h0000_FFFF);
        check("t2_underrun", 64'(und), 64'd0);
        enable_a = 1'b0;

        // 3: 4 channels, 12-bit samples in 16-bit slots, LJ
        in_valid_b = 1'b1; in_data_b = {12'h000, 12'h800, 12'h001, 12'hFFF};
        step();
        in_valid_b = 1'b0;
        check("t3_level", 64'(fifo_level_b), 64'd1);
        enable_b = 1'b1;
        grab(1'b1, 64, bits, lr, r1, r2, und);
        check("t3_bits",     bits, 64'hFFF0_0010_8000_0000);
        check("t3_lrclk",    lr,   64'h0000_0000_FFFF_FFFF);
        check("t3_underrun", 64'(und), 64'd0);
        enable_b = 1'b0;

        // 4: enable with empty FIFO, one push mid-frame 0
        do_reset();
        mode_a = 1'b0; prescaler_a = 8'd4;
        enable_a = 1'b1;
        und = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid_a = (i == 100);
            in_data_a  = $urandom;
            step();
            if (underrun_a) und++;
        end
        in_valid_a = 1'b0;
        check("t4_underrun_count", 64'(und), 64'd1);

        // 5: five pushes into a depth-4 FIFO while idle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 1'b1; in_data_a = $urandom;
            step();
        end
        check("t5_level_full", 64'(fifo_level_a), 64'd4);
        check("t5_ready_low",  64'(in_ready_a), 64'd0);
        in_data_a = 32'h1234_5678;
        step();
        check("t5_fifth_held", 64'(fifo_level_a), 64'd4);
        enable_a = 1'b1;
        step();
        check("t5_ready_after_pop", 64'(in_ready_a), 64'd1);
        step();
        in_valid_a = 1'b0;
        check("t5_level_refill", 64'(fifo_level_a), 64'd4);
        check("t5_ready_refill", 64'(in_ready_a), 64'd0);

        // 6: reset mid-frame with 3 queued, then a mid-frame prescaler change
        do_reset();
        enable_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_a = 1'b1; in_data_a = $urandom;
            step();
        end
        in_valid_a = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("t6_level_before", 64'(fifo_level_a), 64'd3);
        check("t6_sclk_before",  64'(sclk_a), 64'd1);
        rst = 1'b1;
        step();
        check("t6_sclk",     64'(sclk_a), 64'd0);
        check("t6_lrclk",    64'(lrclk_a), 64'd0);
        check("t6_sdata",    64'(sdata_a), 64'd0);
        check("t6_underrun", 64'(underrun_a), 64'd0);
        check("t6_level",    64'(fifo_level_a), 64'd0);
        check("t6_ready",    64'(in_ready_a), 64'd0);
        rst = 1'b0;
        step();
        check("t6_ready_after", 64'(in_ready_a), 64'd1);
        for (int i = 0; i < 50; i++) step();
        prescaler_a = 8'd2;
        for (int i = 0; i < 400; i++) step();

        // Random traffic with busy and starved phases
        prescaler_a = 8'd1;
        for (int i = 0; i < 5000; i++) begin
            if (((i / 1000) % 2) == 0) in_valid_a = ($urandom_range(0, 3) == 0);
            else                       in_valid_a = ($urandom_range(0, 99) == 0);
            in_data_a = $urandom;
            if ($urandom_range(0, 199) == 0) prescaler_a = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) mode_a = ~mode_a;
            if ($urandom_range(0, 799) == 0) enable_a = ~enable_a;
            step();
        end
        in_valid_a = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
Parametrised successor to the existing two-channel I2S transmitter that drives the board codec path.
- Serialises CHANNELS audio samples per frame, with configurable sample and slot widths.
- Supports standard I2S and left-justified framing.
- Buffers whole frames in a small FIFO with a valid/ready input, and flags underruns.
- Sits between the core's AUDIO outputs (or a future mixer) and the codec pins, clocked from the fast system clock.

Parameters:
SAMPLE_W, 16, bits per sample; 1 ≤ SAMPLE_W ≤ SLOT_W.
SLOT_W, 16, bits per channel slot; sample is sent MSB-first, then zero padding.
CHANNELS, 2, slots per frame; even, 2..8.
FIFO_DEPTH, 4, frames buffered; power of two, ≥ 2.
PRESCALE_W, 8, width of the prescaler input.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run serial interface; low = idle
mode  in  1  0 = I2S (1-bit delay), 1 = left-justified
prescaler  in  PRESCALE_W  sclk half-period in clk cycles; 0 treated as 1
in_valid  in  1  frame present on in_data
in_ready  out  1  FIFO can accept a frame
in_data  in  CHANNELS*SAMPLE_W  frame; channel 0 in the LSBs
sclk  out  1  serial bit clock
lrclk  out  1  word/frame select
sdata  out  1  serial data
underrun  out  1  one-clk pulse when a frame starts with the FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored

Behaviour:
- Reset:
  - sclk, lrclk, sdata and underrun = 0; FIFO empty; fifo_level = 0.
  - in_ready = 0 while rst is high, 1 on the first cycle after.
  - Reset mid-frame aborts the frame and discards FIFO contents.
- Input handshake:
  - Push on in_valid & in_ready.
  - in_ready = (fifo_level != FIFO_DEPTH), registered.
  - Push and pop in the same cycle: level unchanged.
  - Push into an empty FIFO in the cycle its frame-start pop occurs: underrun fires; the pushed frame plays in the next frame.
- Bit clock:
  - The prescale counter counts 0..P-1, where P = max(prescaler, 1); sclk toggles at terminal count.
  - Half period is exactly P clk cycles.
- Bit counter:
  - bitcnt runs 0..CHANNELS*SLOT_W-1, advances on each sclk falling edge and wraps.
- sdata update (on the sclk falling edge):
  - Output bit = bit (SLOT_W-1 - bitcnt mod SLOT_W) of the slot (bitcnt / SLOT_W) of the current frame.
  - Slot bits below the sample (SLOT_W-SAMPLE_W LSBs) are 0.
  - Receivers sample on the rising edge.
- lrclk:
  - LJ mode: lrclk = (bitcnt ≥ CHANNELS*SLOT_W/2).
  - I2S mode: lrclk uses ((bitcnt+1) mod frame) in the same test, so lrclk leads the data by one sclk. Data itself is not delayed; the frame MSB appears one sclk after the lrclk falling edge.
- Frame start (bitcnt wraps to 0, at the falling edge that emits bit 0):
  - Pop the FIFO head into the frame shift register.
  - If the FIFO is empty, load zeros and pulse underrun for 1 clk.
  - mode and prescaler are sampled only at frame start and on enable rise; mid-frame changes take effect next frame.
- enable low:
  - Within 1 clk: sclk = 0, lrclk = 0, sdata = 0; counters cleared.
  - FIFO contents and pushes are retained.
- enable rise:
  - First sclk rising edge after P cycles.
  - Frame 0 is loaded at the enable edge, using pop/underrun rules as above.
- CHANNELS = 2, SLOT_W = 16 is bit-exact with the legacy transmitter in I2S mode.

Decomposition:
- audio_pkg holds:
  - constants MODE_I2S = 1'b0 and MODE_LJ = 1'b1;
  - a width helper function for fifo_level.
- One sub-module: sync_fifo (WIDTH, DEPTH).
  - Single clock with registered full/empty and a level output; read data is available the same cycle as pop (first-word fall-through).
- Prescaler, bit counter, lrclk logic and shift register stay in i2s_tdm_tx.

Test Plan:
1. Defaults, I2S, prescaler = 4, push frames {L=16'hA5F0, R=16'h0F0F}.
   -> sclk period 8 clk.
   -> lrclk falls, then 1 sclk later bits 1010_0101_1111_0000 on rising edges.
   -> lrclk rises 1 sclk before R MSB; no underrun.
2. Same stimulus in LJ mode.
   -> The MSB of L coincides with the lrclk falling edge.
   -> The frame is 32 sclk periods long.
3. CHANNELS = 4, SAMPLE_W = 12, SLOT_W = 16; push samples 12'hFFF, 12'h001, 12'h800, 12'h000.
   -> Slot streams are FFF0, 0010, 8000, 0000.
   -> lrclk is high for the second 32 bits.
4. Enable with the FIFO empty.
   -> underrun pulses once per frame; sdata is all zeros.
   -> Push 1 frame mid-frame: it is sent on the next frame; no underrun for that frame.
5. Push 5 frames back-to-back with FIFO_DEPTH = 4 while idle.
   -> in_ready drops after 4; fifo_level = 4.
   -> The 5th frame is accepted only after the first pop.
6. Assert rst mid-frame with 3 frames queued.
   -> Next cycle: all outputs 0, fifo_level = 0.
   -> in_ready = 1 the cycle after rst deasserts.
   -> Change prescaler mid-frame: the new rate starts at the next frame boundary.
